// File: rtl/mem_bus_pkg.sv
// Shared types for the uncached data path: the bus word width, the posted-write
// entry layout and the read state machine encoding.
package mem_bus_pkg;

  localparam int BUS_WORD_W = 32;
  localparam int BUS_MASK_W = BUS_WORD_W / 8;

  typedef struct packed {
    logic [BUS_WORD_W-1:0] addr;
    logic [BUS_WORD_W-1:0] wdata;
    logic [BUS_MASK_W-1:0] wmask;
  } bus_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_REQ  = 2'd1,
    ST_RD_DONE = 2'd2
  } uwb_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and a combinationally readable head.
// Push is ignored when full and pop is ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uncached_write_buffer.sv
// Posted-write buffer for uncached CPU accesses: stores retire into a FIFO and
// drain in order; loads wait for the FIFO to empty, then issue one bus read.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | draining posted writes; a load latches its address once empty
// ST_RD_REQ  | bus read outstanding with the latched address
// ST_RD_DONE | rdata holds the read result; CPU released this cycle
module uncached_write_buffer
  import mem_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rreq,
  input  logic                  wreq,
  input  logic [BUS_WORD_W-1:0] addr,
  input  logic [BUS_WORD_W-1:0] wdata,
  input  logic [BUS_MASK_W-1:0] wmask,
  output logic [BUS_WORD_W-1:0] rdata,
  output logic                  miss,
  output logic                  idle,
  output logic                  bus_rreq,
  output logic                  bus_wreq,
  output logic [BUS_WORD_W-1:0] bus_addr,
  output logic [BUS_WORD_W-1:0] bus_wdata,
  output logic [BUS_MASK_W-1:0] bus_wmask,
  input  logic                  bus_acc,
  input  logic [BUS_WORD_W-1:0] bus_rdata,
  input  logic                  bus_busy
);

  localparam int AW = $clog2(DEPTH);

  uwb_state_t            state;
  uwb_state_t            state_nxt;
  logic [BUS_WORD_W-1:0] rd_addr;
  bus_entry_t            push_entry;
  bus_entry_t            head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [AW:0]           fifo_count;
  logic                  push;
  logic                  pop;
  logic                  bus_done;
  logic                  wr_active;
  logic                  rd_active;
  logic                  rd_start;

  assign push_entry = '{addr: addr, wdata: wdata, wmask: wmask};

  // A load in the same cycle takes priority, so the store is not posted.
  assign push      = wreq & ~rreq & ~fifo_full;
  assign bus_done  = bus_acc & ~bus_busy;
  assign wr_active = (state == ST_IDLE) & ~fifo_empty;
  assign rd_active = (state == ST_RD_REQ);
  assign pop       = wr_active & bus_done;
  assign rd_start  = (state == ST_IDLE) & fifo_empty & rreq;

  assign miss = (rreq & (state != ST_RD_DONE)) | (wreq & ~rreq & fifo_full);
  assign idle = (fifo_count == '0) & (state == ST_IDLE);

  sync_fifo #(
    .WIDTH ($bits(bus_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      rd_addr <= '0;
      rdata   <= '0;
    end else begin
      state <= state_nxt;
      if (rd_start) begin
        rd_addr <= addr;
      end
      if (rd_active && bus_done) begin
        rdata <= bus_rdata;
      end
    end
  end

  // The read completes even if the CPU drops rreq mid-flight.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (rd_start) begin
          state_nxt = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (bus_done) begin
          state_nxt = ST_RD_DONE;
        end
      end
      ST_RD_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    bus_rreq  = 1'b0;
    bus_wreq  = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_wmask = '0;
    if (rd_active) begin
      bus_rreq = 1'b1;
      bus_addr = rd_addr;
    end else if (wr_active) begin
      bus_wreq  = 1'b1;
      bus_addr  = head.addr;
      bus_wdata = head.wdata;
      bus_wmask = head.wmask;
    end
  end

endmodule

// File: tb/tb_uncached_write_buffer.sv
// Self-checking bench for uncached_write_buffer: store vector table, directed
// multi-cycle corner sequences and a randomized run against a queue-based model.
module tb_uncached_write_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        rreq;
  logic        wreq;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic [31:0] rdata;
  logic        miss;
  logic        idle;
  logic        bus_rreq;
  logic        bus_wreq;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wmask;
  logic        bus_acc;
  logic [31:0] bus_rdata;
  logic        bus_busy;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  uncached_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .rreq      (rreq),
    .wreq      (wreq),
    .addr      (addr),
    .wdata     (wdata),
    .wmask     (wmask),
    .rdata     (rdata),
    .miss      (miss),
    .idle      (idle),
    .bus_rreq  (bus_rreq),
    .bus_wreq  (bus_wreq),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_wmask (bus_wmask),
    .bus_acc   (bus_acc),
    .bus_rdata (bus_rdata),
    .bus_busy  (bus_busy)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    int          busy_cycles;
    int          exp_wreq_cycles;
  } store_vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } ent_t;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_quiet();
    rreq  = 1'b0;
    wreq  = 1'b0;
    addr  = '0;
    wdata = '0;
    wmask = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cpu_quiet();
    bus_acc   = 1'b0;
    bus_busy  = 1'b0;
    bus_rdata = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  store_vec_t vecs[4];
  ent_t       q[$];

  initial begin
    int idx, pops, stall, wdone, got, rdc, missc, done_flag, wcnt, phase, op;
    logic hold, full, e_wreq, e_rreq, e_miss, e_idle, bus_done;
    logic [31:0] m_lat, m_rdata;
    ent_t e;

    vecs[0] = '{32'hBFD0_03F8, 32'h0000_0041, 4'b0001, 0, 1};
    vecs[1] = '{32'h1FC0_0104, 32'hDEAD_BEEF, 4'b1111, 2, 3};
    vecs[2] = '{32'hA000_0002, 32'h0000_AB00, 4'b0010, 1, 2};
    vecs[3] = '{32'h8000_FFFC, 32'h1234_0000, 4'b1100, 3, 4};

    // Reset values, and miss following rreq while reset holds the FSM in idle.
    do_reset();
    reset = 1'b1;
    rreq  = 1'b1;
    @(negedge clk);
    chk1("rst_miss_follows_rreq", miss, 1'b1);
    step();
    reset = 1'b0;
    rreq  = 1'b0;
    @(negedge clk);
    chk1("rst_bus_rreq", bus_rreq, 1'b0);
    chk1("rst_bus_wreq", bus_wreq, 1'b0);
    chk32("rst_bus_addr", bus_addr, 32'h0);
    chk32("rst_bus_wdata", bus_wdata, 32'h0);
    chk32("rst_bus_wmask", {28'h0, bus_wmask}, 32'h0);
    chk1("rst_idle", idle, 1'b1);
    chk32("rst_rdata", rdata, 32'h0);
    chk1("rst_miss", miss, 1'b0);
    step();

    // Single-store table: zero-stall push, triple held until completion.
    foreach (vecs[i]) begin
      bus_acc  = 1'b1;
      bus_busy = 1'b0;
      wreq  = 1'b1;
      addr  = vecs[i].a;
      wdata = vecs[i].d;
      wmask = vecs[i].m;
      @(negedge clk);
      chk1("tbl_push_miss", miss, 1'b0);
      chk1("tbl_push_no_wreq_yet", bus_wreq, 1'b0);
      step();
      cpu_quiet();
      wcnt = 0;
      for (int k = 0; k < 20 && !idle; k++) begin
        bus_busy = (k < vecs[i].busy_cycles);
        @(negedge clk);
        if (bus_wreq) begin
          wcnt++;
          chk32("tbl_bus_addr", bus_addr, vecs[i].a);
          chk32("tbl_bus_wdata", bus_wdata, vecs[i].d);
          chk32("tbl_bus_wmask", {28'h0, bus_wmask}, {28'h0, vecs[i].m});
        end
        step();
      end
      bus_busy = 1'b0;
      chk32("tbl_wreq_cycles", 32'(wcnt), 32'(vecs[i].exp_wreq_cycles));
      @(negedge clk);
      chk1("tbl_idle_after", idle, 1'b1);
      step();
    end

    // Five back-to-back stores into a 4-deep FIFO with the bus busy 10 cycles.
    do_reset();
    bus_acc = 1'b1;
    idx = 0; pops = 0; stall = 0;
    for (int cyc = 0; cyc < 60 && pops < 5; cyc++) begin
      bus_busy = (cyc < 10);
      wreq  = (idx < 5);
      addr  = 32'h1000_0000 + 32'(idx * 4);
      wdata = 32'hA0 + 32'(idx);
      wmask = 4'hF;
      @(negedge clk);
      if (idx < 4) chk1("five_st_accept", miss, 1'b0);
      else if (idx == 4) begin
        chk1("five_st_fifth_miss", miss, pops == 0);
        if (miss) stall++;
      end
      if (bus_wreq && !bus_busy) begin
        chk32("five_st_order_addr", bus_addr, 32'h1000_0000 + 32'(pops * 4));
        chk32("five_st_order_data", bus_wdata, 32'hA0 + 32'(pops));
        pops++;
      end
      if (idx < 5 && !miss) idx++;
      step();
    end
    cpu_quiet();
    chk32("five_st_drained", 32'(pops), 32'd5);
    chk32("five_st_stall", 32'(stall), 32'd7);

    // Two stores then a load: the read waits for both writes.
    do_reset();
    bus_acc = 1'b1;
    bus_busy = 1'b0;
    bus_rdata = 32'h1234_5678;
    idx = 0; wdone = 0; got = 0;
    for (int cyc = 0; cyc < 30 && !got; cyc++) begin
      if (idx < 2) begin
        wreq = 1'b1; rreq = 1'b0;
        addr = 32'hBFD0_0000 + 32'(idx * 4);
        wdata = 32'h55 + 32'(idx);
        wmask = 4'hF;
      end else begin
        wreq = 1'b0; rreq = 1'b1;
        addr = 32'hBFD0_03FC;
      end
      @(negedge clk);
      chk1("ldst_excl", bus_rreq & bus_wreq, 1'b0);
      if (bus_wreq) wdone++;
      if (bus_rreq) begin
        chk32("ldst_writes_before_read", 32'(wdone), 32'd2);
        chk32("ldst_read_addr", bus_addr, 32'hBFD0_03FC);
      end
      if (idx == 2 && !miss) begin
        chk32("ldst_rdata", rdata, 32'h1234_5678);
        got = 1;
      end
      if (idx < 2) idx++;
      step();
    end
    cpu_quiet();
    chk32("ldst_completed", 32'(got), 32'd1);

    // Load with bus_acc withheld for the first 3 request cycles.
    do_reset();
    bus_busy = 1'b0;
    bus_rdata = 32'hCAFE_F00D;
    rreq = 1'b1;
    addr = 32'h1FC0_0010;
    rdc = 0; missc = 0; done_flag = 0;
    for (int cyc = 0; cyc < 20 && !done_flag; cyc++) begin
      bus_acc = (rdc >= 3);
      @(negedge clk);
      if (bus_rreq) begin
        chk32("dly_bus_addr_stable", bus_addr, 32'h1FC0_0010);
        rdc++;
      end
      if (miss) missc++;
      else begin
        done_flag = 1;
        chk32("dly_rdata", rdata, 32'hCAFE_F00D);
      end
      step();
    end
    cpu_quiet();
    chk32("dly_miss_cycles", 32'(missc), 32'd5);
    chk32("dly_rreq_cycles", 32'(rdc), 32'd4);

    // rreq dropped while the read is outstanding.
    do_reset();
    bus_busy = 1'b0;
    bus_acc = 1'b0;
    bus_rdata = 32'h5A5A_1234;
    rreq = 1'b1;
    addr = 32'h1FD0_0020;
    @(negedge clk);
    chk1("flush_c0_miss", miss, 1'b1);
    chk1("flush_c0_no_rreq", bus_rreq, 1'b0);
    step();
    rreq = 1'b0;
    @(negedge clk);
    chk1("flush_c1_rreq", bus_rreq, 1'b1);
    chk1("flush_c1_miss", miss, 1'b0);
    step();
    bus_acc = 1'b1;
    @(negedge clk);
    chk1("flush_c2_rreq", bus_rreq, 1'b1);
    step();
    @(negedge clk);
    chk1("flush_c3_no_rreq", bus_rreq, 1'b0);
    chk1("flush_c3_not_idle", idle, 1'b0);
    chk32("flush_c3_rdata", rdata, 32'h5A5A_1234);
    step();
    @(negedge clk);
    chk1("flush_c4_idle", idle, 1'b1);
    chk1("flush_c4_no_rreq", bus_rreq, 1'b0);
    step();
    @(negedge clk);
    chk1("flush_c5_no_rreq", bus_rreq, 1'b0);
    chk1("flush_c5_no_wreq", bus_wreq, 1'b0);
    step();

    // Reset with 3 posted writes and a pending load.
    bus_busy = 1'b1;
    bus_acc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wreq = 1'b1;
      addr = 32'h2000_0000 + 32'(i * 4);
      wdata = 32'(i);
      wmask = 4'hF;
      step();
    end
    wreq = 1'b0;
    rreq = 1'b1;
    addr = 32'h2000_0100;
    @(negedge clk);
    chk1("rstmid_pre_miss", miss, 1'b1);
    chk1("rstmid_pre_wreq", bus_wreq, 1'b1);
    chk32("rstmid_pre_rdata", rdata, 32'h5A5A_1234);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    cpu_quiet();
    bus_busy = 1'b0;
    @(negedge clk);
    chk1("rstmid_bus_rreq", bus_rreq, 1'b0);
    chk1("rstmid_bus_wreq", bus_wreq, 1'b0);
    chk1("rstmid_idle", idle, 1'b1);
    chk32("rstmid_rdata", rdata, 32'h0);
    step();

    // Randomized traffic against a queue-based reference model.
    do_reset();
    q.delete();
    phase = 0;          // 0: writes draining / idle, 1: read on bus, 2: read data returned
    m_lat = '0;
    m_rdata = '0;
    hold = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!hold) begin
        op = int'($urandom_range(0, 5));
        rreq  = (op == 2 || op == 5);
        wreq  = (op == 1 || op == 3 || op == 5);
        addr  = $urandom;
        wdata = $urandom;
        wmask = 4'($urandom);
      end
      bus_acc   = ($urandom_range(0, 3) != 0);
      bus_busy  = ($urandom_range(0, 3) == 0);
      bus_rdata = $urandom;
      full   = (q.size() == DEPTH);
      e_wreq = (phase == 0) && (q.size() > 0);
      e_rreq = (phase == 1);
      e_miss = (rreq && phase != 2) || (wreq && !rreq && full);
      e_idle = (phase == 0) && (q.size() == 0);
      @(negedge clk);
      chk1("rnd_bus_wreq", bus_wreq, e_wreq);
      chk1("rnd_bus_rreq", bus_rreq, e_rreq);
      chk1("rnd_miss", miss, e_miss);
      chk1("rnd_idle", idle, e_idle);
      chk32("rnd_rdata", rdata, m_rdata);
      if (e_wreq) begin
        chk32("rnd_w_addr", bus_addr, q[0].a);
        chk32("rnd_w_data", bus_wdata, q[0].d);
        chk32("rnd_w_mask", {28'h0, bus_wmask}, {28'h0, q[0].m});
      end
      if (e_rreq) chk32("rnd_r_addr", bus_addr, m_lat);
      hold = e_miss;
      bus_done = (e_wreq || e_rreq) && bus_acc && !bus_busy;
      case (phase)
        0: begin
          if (q.size() > 0) begin
            if (bus_done) void'(q.pop_front());
          end else if (rreq) begin
            phase = 1;
            m_lat = addr;
          end
        end
        1: if (bus_done) begin
          m_rdata = bus_rdata;
          phase = 2;
        end
        default: phase = 0;
      endcase
      if (wreq && !rreq && !full) begin
        e = '{addr, wdata, wmask};
        q.push_back(e);
      end
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uncached_write_buffer.md
# uncached_write_buffer

Posted-write buffer for the uncached data path. It sits between the CPU data port (uncached `rreq`/`wreq` qualified by `uncached`) and bus master port 1 of `BusController`. Uncached stores retire in one cycle into a small FIFO and drain to the bus in order. Uncached loads stall until the FIFO is empty, then issue a single bus read, which gives strict program-order visibility for MMIO.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.

Ports:
- `clk` in 1: system clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `rreq` in 1: uncached load request; held by CPU while `miss`=1.
- `wreq` in 1: uncached store request; held by CPU while `miss`=1.
- `addr` in 32: byte address, word-aligned for the bus (`addr[1:0]` forwarded unchanged).
- `wdata` in 32: store data.
- `wmask` in 4: byte enables for the store.
- `rdata` out 32: load data, registered.
- `miss` out 1: stall the CPU this cycle.
- `idle` out 1: FIFO empty and state IDLE.
- `bus_rreq` out 1: bus read request.
- `bus_wreq` out 1: bus write request.
- `bus_addr` out 32: bus address.
- `bus_wdata` out 32: bus write data.
- `bus_wmask` out 4: bus byte enables; slaves without mask support treat it as 4'b1111.
- `bus_acc` in 1: bus accepted/completed this master's request this cycle.
- `bus_rdata` in 32: read data, valid in the completing cycle.
- `bus_busy` in 1: bus busy; no completion while high.

## Operation
- Bus completion: a request completes at the rising edge where it is asserted and `bus_acc`=1 and `bus_busy`=0. `bus_addr`, `bus_wdata`, and `bus_wmask` are held stable until completion.
- State machine IDLE / RD_REQ / RD_DONE.
- IDLE:
  - FIFO non-empty: present the head on the bus with `bus_wreq`=1. Pop on completion.
  - `rreq`=1 and FIFO empty: latch `addr`, then go to RD_REQ.
- RD_REQ: `bus_rreq`=1 with the latched address, `bus_wreq`=0. On completion, capture `bus_rdata` into `rdata`, then go to RD_DONE.
- RD_DONE: `rdata` valid. Go to IDLE next cycle.
- `miss` (combinational) = (`rreq` & state≠RD_DONE) | (`wreq` & ~`rreq` & full).
- Store push: occurs at the edge where `wreq`=1, `rreq`=0, and not full, with entry {addr, wdata, wmask}.
- Full is computed from the registered count. There is no same-cycle bypass: a pop in the same cycle does not admit a push when full.
- `rreq` and `wreq` both high: `rreq` wins and the write is ignored.
- `rreq` dropped during RD_REQ (pipeline flush): the bus read still completes, the data is captured, and the block passes through RD_DONE normally.
- No write is pushed while state≠IDLE, because the CPU is stalled on the read.
- Push and pop in the same cycle: the count is unchanged and the pointers wrap modulo DEPTH.

## Timing
- Reset values: state IDLE, FIFO empty, `rdata`=0, `bus_rreq`=`bus_wreq`=0, `bus_addr`/`bus_wdata`=0, `bus_wmask`=0, `idle`=1. `miss` follows `rreq` after reset.
- Reset mid-operation: posted writes are discarded and an in-flight read is abandoned. Bus requests drop in the cycle after the reset edge.
- Store: zero stall cycles when not full. The first bus write is asserted in the cycle after the push.
- Load, FIFO empty, zero-wait bus:
  - cycle 0: `rreq`, `miss`=1
  - cycle 1: `bus_rreq`=1, `bus_acc`=1
  - cycle 2: RD_DONE, `miss`=0, `rdata` valid
  - Minimum latency is 2 stall cycles. Each `bus_busy` or `~bus_acc` cycle adds one.
- Load behind N posted writes: the read starts in the cycle after the last write completes.
- `bus_rreq` and `bus_wreq` are never high together.

## Structure
- Shared package `mem_bus_pkg`: bus request/entry struct {addr, wdata, wmask}, state enum, `BUS_WORD_W`=32.
- Sub-module `sync_fifo` (parameterised width/depth):
  - push/pop/full/empty/count.
  - Registered pointers with synchronous reset.
  - Head readable combinationally.
- The FSM and bus muxing live in the top module.

## Test plan
- Single store `addr`=0xBFD003F8, `wdata`=0x41, `wmask`=0001, bus zero-wait → `miss`=0. Next cycle `bus_wreq`=1 with the same triple. `idle`=1 after completion.
- Five back-to-back stores with `DEPTH`=4 and `bus_busy`=1 for 10 cycles → the first four are accepted. The fifth sees `miss`=1 until the first pop, and the bus order matches program order.
- Two stores then a load to 0xBFD003FC → `bus_rreq` is not asserted until both writes complete. `rdata`=`bus_rdata`=0x12345678 in RD_DONE with `miss`=0.
- Load with `bus_acc` delayed 3 cycles → `miss`=1 for 5 cycles. `bus_addr` is stable throughout.
- `rreq` dropped during RD_REQ → the read completes, the FSM returns to IDLE two cycles later, and no extra bus request is made.
- Reset asserted with 3 entries queued and a read pending → the next cycle shows `bus_rreq`=`bus_wreq`=0, `idle`=1, `rdata`=0.
